// File: rtl/setup_sweep_ctrl.sv
// Setup-margin sweep sequencer: launches data at a shrinking offset ahead of a
// periodic capture strobe and records whether the flop-under-test captured it.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// CLEAR  | d_out low for PERIOD cycles, strobe at last phase forces the flop to 0
// LAUNCH | d_out rises off_k cycles before the strobe at the last phase
// CHECK  | sample q_in into pass_mask, advance to the next case
// DONE   | one-cycle done pulse
module setup_sweep_ctrl #(
  parameter int PERIOD    = 10,
  parameter int NUM_CASES = 6,
  parameter int OFS_START = 9,
  parameter int OFS_STEP  = 2,
  localparam int CW = (NUM_CASES > 1) ? $clog2(NUM_CASES) : 1,
  localparam int FW = $clog2(NUM_CASES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 q_in,
  output logic                 d_out,
  output logic                 cap_en,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        case_idx,
  output logic [NUM_CASES-1:0] pass_mask,
  output logic [FW-1:0]        fail_cnt
);

  localparam int PW   = $clog2(PERIOD);
  localparam int OFS0 = (OFS_START < 0) ? 0 :
                        (OFS_START > PERIOD - 1) ? PERIOD - 1 : OFS_START;
  localparam logic [PW-1:0] PH_LAST   = PW'(PERIOD - 1);
  localparam logic [CW-1:0] LAST_CASE = CW'(NUM_CASES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, CHECK, DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic          start_acc;
  logic          d_n, cap_n, busy_n, done_n;
  logic [31:0]   dec, off_k, rise_ph;

  // offset saturates at 0 instead of wrapping when the step overshoots
  assign dec     = 32'(case_idx) * 32'(OFS_STEP);
  assign off_k   = (dec >= 32'(OFS0)) ? 32'd0 : 32'(OFS0) - dec;
  assign rise_ph = 32'(PERIOD - 1) - off_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= '0;
      d_out  <= 1'b0;
      cap_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      d_out  <= d_n;
      cap_en <= cap_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // outputs are derived from the next state so they line up with the state they describe
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = CLEAR;
          phase_n   = '0;
          start_acc = 1'b1;
        end
      end
      CLEAR: begin
        if (phase == PH_LAST) begin
          state_n = LAUNCH;
          phase_n = '0;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      LAUNCH: begin
        if (phase == PH_LAST) begin
          state_n = CHECK;
          phase_n = '0;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      CHECK: begin
        state_n = (case_idx == LAST_CASE) ? DONE : CLEAR;
        phase_n = '0;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    d_n    = (state_n == LAUNCH) && (32'(phase_n) >= rise_ph);
    cap_n  = ((state_n == CLEAR) || (state_n == LAUNCH)) && (phase_n == PH_LAST);
    busy_n = (state_n == CLEAR) || (state_n == LAUNCH) || (state_n == CHECK);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      case_idx  <= '0;
      pass_mask <= '0;
      fail_cnt  <= '0;
    end else if (start_acc) begin
      case_idx  <= '0;
      pass_mask <= '0;
      fail_cnt  <= '0;
    end else if (state == CHECK) begin
      pass_mask[case_idx] <= q_in;
      if (!q_in) fail_cnt <= fail_cnt + 1'b1;
      if (case_idx != LAST_CASE) case_idx <= case_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_setup_sweep_ctrl.sv
// Directed bench for setup_sweep_ctrl: per-case vector table plus hand-written
// sequences for restart, reset, DONE-cycle start and the clamped-offset build.
module tb_setup_sweep_ctrl;

  localparam int P = 10, N = 6, CYC = 2 * P + 1, DONE_C = 1 + N * CYC;
  localparam int P2 = 4, N2 = 3, CYC2 = 2 * P2 + 1, DONE2 = 1 + N2 * CYC2;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, q_in = 1'b0;
  logic       d_out, cap_en, busy, done;
  logic [2:0] case_idx;
  logic [5:0] pass_mask;
  logic [2:0] fail_cnt;

  logic       start2 = 1'b0, q2 = 1'b0;
  logic       d2, cap2, busy2, done2;
  logic [1:0] idx2;
  logic [2:0] pm2;
  logic [1:0] fc2;

  always #5 clk = ~clk;

  setup_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .q_in(q_in), .d_out(d_out), .cap_en(cap_en),
    .busy(busy), .done(done), .case_idx(case_idx), .pass_mask(pass_mask), .fail_cnt(fail_cnt)
  );

  setup_sweep_ctrl #(.PERIOD(P2), .NUM_CASES(N2), .OFS_START(9), .OFS_STEP(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .q_in(q2), .d_out(d2), .cap_en(cap2),
    .busy(busy2), .done(done2), .case_idx(idx2), .pass_mask(pm2), .fail_cnt(fc2)
  );

  // flop-under-test: ideal, or needing d high for >=4 cycles including the strobe
  bit slow = 1'b0;
  int hi_run = 0;
  always @(posedge clk) begin
    if (cap_en) q_in <= slow ? (d_out && hi_run >= 3) : d_out;
    hi_run <= d_out ? hi_run + 1 : 0;
    if (cap2) q2 <= d2;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int rise;
    bit pass_slow;
  } vec_t;
  vec_t tbl[N];

  int rise_obs[N];
  int strobes, bad_clear, bad_launch, bad_idx, bad_busy, done_c;

  task automatic run_sweep(input int extra_c);
    int k, w, ph;
    for (int i = 0; i < N; i++) rise_obs[i] = -1;
    strobes = 0; bad_clear = 0; bad_launch = 0; bad_idx = 0; bad_busy = 0; done_c = 0;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= DONE_C + 1; c++) begin
      @(negedge clk);
      k = (c - 1) / CYC;
      w = (c - 1) % CYC;
      if (k < N) begin
        if (!busy || done) bad_busy++;
        if (case_idx != k) bad_idx++;
        if (w < P) begin
          if (d_out || cap_en != (w == P - 1)) bad_clear++;
        end else if (w < 2 * P) begin
          ph = w - P;
          if (cap_en != (ph == P - 1)) bad_launch++;
          if (d_out && rise_obs[k] < 0) rise_obs[k] = ph;
          else if (!d_out && rise_obs[k] >= 0) bad_launch++;
        end else if (d_out || cap_en) bad_launch++;
      end else if (busy || d_out || cap_en || done != (w == 0)) bad_busy++;
      if (cap_en) strobes++;
      if (done && done_c == 0) done_c = c;
      start = (c == extra_c);
    end
    start = 1'b0;
  endtask

  task automatic check_sweep(input string tag, input bit slow_mode);
    chk({tag, " done_cycle"}, done_c, DONE_C);
    chk({tag, " strobes"}, strobes, 12);
    chk({tag, " clear_errs"}, bad_clear, 0);
    chk({tag, " launch_errs"}, bad_launch, 0);
    chk({tag, " idx_errs"}, bad_idx, 0);
    chk({tag, " busy_done_errs"}, bad_busy, 0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s rise_case%0d", tag, k), rise_obs[k], tbl[k].rise);
      chk($sformatf("%s pass_case%0d", tag, k), pass_mask[k], slow_mode ? tbl[k].pass_slow : 1'b1);
    end
    chk({tag, " fail_cnt"}, fail_cnt, slow_mode ? 2 : 0);
    chk({tag, " case_idx_hold"}, case_idx, N - 1);
  endtask

  initial begin
    int hi_l, hi_o, st2, dn2, k, w;
    tbl[0] = '{0, 1'b1}; tbl[1] = '{2, 1'b1}; tbl[2] = '{4, 1'b1};
    tbl[3] = '{6, 1'b1}; tbl[4] = '{8, 1'b0}; tbl[5] = '{9, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {d_out, cap_en, busy, done, case_idx, pass_mask, fail_cnt}, 0);
    chk("reset_outputs2", {d2, cap2, busy2, done2, idx2, pm2, fc2}, 0);
    rst = 1'b0;
    @(negedge clk);

    slow = 1'b0;
    run_sweep(0);
    check_sweep("ideal", 1'b0);

    slow = 1'b1;
    run_sweep(0);
    check_sweep("slow", 1'b1);
    slow = 1'b0;

    // start during case 2 must not disturb the sweep
    run_sweep(2 * CYC + 8);
    check_sweep("restart_ignored", 1'b0);

    // start in the DONE cycle is ignored
    run_sweep(DONE_C);
    chk("done_start_busy", busy, 1'b0);
    chk("done_start_case_idx", case_idx, N - 1);

    // reset during LAUNCH of case 3
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3 * CYC + P + 3 - 1) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    chk("pre_reset_idx", case_idx, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {d_out, cap_en, busy, done, case_idx, pass_mask, fail_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // rst wins over start in the same cycle
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 1'b0);
    @(negedge clk);
    chk("rst_start_busy_later", busy, 1'b0);

    run_sweep(0);
    check_sweep("after_reset", 1'b0);

    // PERIOD=4 build: offset clamps to 3, so d_out is high for every LAUNCH phase
    hi_l = 0; hi_o = 0; st2 = 0; dn2 = 0;
    @(negedge clk) start2 = 1'b1;
    for (int c = 1; c <= DONE2 + 1; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      k = (c - 1) / CYC2;
      w = (c - 1) % CYC2;
      if (k < N2 && w >= P2 && w < 2 * P2) hi_l += int'(d2);
      else hi_o += int'(d2);
      if (cap2) st2++;
      if (done2 && dn2 == 0) dn2 = c;
    end
    chk("p4 launch_high_cycles", hi_l, N2 * P2);
    chk("p4 high_outside_launch", hi_o, 0);
    chk("p4 strobes", st2, 2 * N2);
    chk("p4 done_cycle", dn2, DONE2);
    chk("p4 pass_mask", pm2, 3'b111);
    chk("p4 fail_cnt", fc2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
